// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-memory requester and the dmem_responder.
// The requester drives the request fields and rsp_ready; the responder answers.
interface dmem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready request/response handshake.
// One request is outstanding at a time; WAIT_CYCLES idle cycles are inserted
// between accepting a request and touching the array, then the response is
// held until the requester takes it.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input logic               CLK,
    input logic               Reset_L,
    dmem_responder_if.slave   bus
);
    localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Extra leading bit so DEPTH_WORDS == 2**(ADDR_W-2) still compares correctly.
    localparam logic [ADDR_W-2:0] IDX_LIMIT = (ADDR_W-1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Merge the enabled bytes of new_word over old_word.
    function automatic logic [31:0] f_byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t            r_state;
    logic [7:0]        r_count;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [31:0]       r_mem [0:DEPTH_WORDS-1];

    logic [ADDR_W-3:0] w_index;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_err;
    logic              w_access;
    logic              w_do_store;
    logic [31:0]       w_rd_word;

    // Decode the latched request: word index, error status and access strobe.
    always_comb begin
        w_index    = r_addr[ADDR_W-1:2];
        w_ram_idx  = w_index[RAM_AW-1:0];
        w_err      = 1'b0;
        w_access   = 1'b0;
        w_do_store = 1'b0;
        w_rd_word  = r_mem[w_ram_idx];
        if ((r_addr[1:0] != 2'b00) || ({1'b0, w_index} >= IDX_LIMIT)) begin
            w_err = 1'b1;
        end else begin
            w_err = 1'b0;
        end
        if ((r_state == ST_BUSY) && (r_count == 8'd0)) begin
            w_access = 1'b1;
        end else begin
            w_access = 1'b0;
        end
        // Reset on the access edge cancels the store.
        if (w_access && r_write && !w_err && Reset_L) begin
            w_do_store = 1'b1;
        end else begin
            w_do_store = 1'b0;
        end
    end

    // Storage array: byte-enabled write on the access edge; contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_do_store) begin
            r_mem[w_ram_idx] <= f_byte_merge(r_mem[w_ram_idx], r_wdata, r_be);
        end
    end

    // Handshake FSM with registered ready/valid/data/error outputs.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_state     <= ST_IDLE;
            r_count     <= 8'd0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_be        <= bus.req_be;
                        r_count     <= 8'(WAIT_CYCLES);
                        r_req_ready <= 1'b0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_count != 8'd0) begin
                        r_count <= r_count - 8'd1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_write) ? 32'd0 : w_rd_word;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_count     <= 8'd0;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule
